// File: rtl/btb_assoc_pkg.sv
// Shared types for the fully-associative branch target buffer.
// Direction counters only exist when BTB_BIMODAL_EN is defined.
package btb_assoc_pkg;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t BTB_CTR_INIT = 2'b10;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_FLUSH = 1'b1
  } btb_state_t;

endpackage

// File: rtl/btb_assoc_entry.sv
// One BTB entry: valid/tag/target registers, tag compares and write control.
// With BTB_BIMODAL_EN defined, the entry also holds a 2-bit saturating counter.
module btb_assoc_entry
  import btb_assoc_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              alloc,
  input  logic              upd_en,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] lkp_pc,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              lkp_match,
  output logic              upd_match,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] target
);

  logic              valid_r;
  logic [ADDR_W-1:0] tag_r;
  logic [ADDR_W-1:0] target_r;

  assign lkp_match = valid_r & (tag_r == lkp_pc);
  assign upd_match = valid_r & (tag_r == upd_pc);
  assign target    = target_r;

  // Valid bit: flush sweep clears, allocation sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (clr) begin
      valid_r <= 1'b0;
    end else if (alloc) begin
      valid_r <= 1'b1;
    end
  end

  // Tag/target payload; a not-taken resolution never overwrites the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r    <= {ADDR_W{1'b0}};
      target_r <= {ADDR_W{1'b0}};
    end else if (alloc) begin
      tag_r    <= upd_pc;
      target_r <= upd_target;
    end else if (upd_en && upd_taken) begin
      target_r <= upd_target;
    end
  end

`ifdef BTB_BIMODAL_EN
  btb_ctr_t ctr_r;
  btb_ctr_t ctr_nxt_s;

  // Saturating counter step for a hit update.
  always_comb begin
    ctr_nxt_s = ctr_r;
    if (upd_taken) begin
      if (ctr_r != 2'b11) ctr_nxt_s = ctr_r + 2'b01;
      else                ctr_nxt_s = ctr_r;
    end else begin
      if (ctr_r != 2'b00) ctr_nxt_s = ctr_r - 2'b01;
      else                ctr_nxt_s = ctr_r;
    end
  end

  // Direction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_r <= BTB_CTR_INIT;
    end else if (alloc) begin
      ctr_r <= BTB_CTR_INIT;
    end else if (upd_en) begin
      ctr_r <= ctr_nxt_s;
    end
  end

  assign pred_taken = ctr_r[1];
`else
  assign pred_taken = 1'b1;
`endif

endmodule

// File: rtl/btb_assoc.sv
// Fully-associative BTB with round-robin replacement and a multi-cycle flush sweep.
// Optional per-entry bimodal direction counters via BTB_BIMODAL_EN.
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lkp_pc,
  output logic              lkp_hit,
  output logic [ADDR_W-1:0] lkp_target,
  output logic              lkp_taken,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              flush,
  output logic              busy
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_state_t        state_r;
  btb_state_t        state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [ENTRIES-1:0] lkp_match_s;
  logic [ENTRIES-1:0] upd_match_s;
  logic [ENTRIES-1:0] pred_taken_s;
  logic [ADDR_W-1:0] target_s [ENTRIES];
  logic              upd_go_s;
  logic              alloc_go_s;
  logic              sweep_last_s;

  // Flush wins over a coincident update; updates during the sweep are dropped.
  assign upd_go_s     = (state_r == BTB_IDLE) & upd_valid & ~flush;
  assign alloc_go_s   = upd_go_s & ~(|upd_match_s) & upd_taken;
  assign sweep_last_s = (idx_r == IDX_W'(ENTRIES - 1));
  assign busy         = (state_r == BTB_FLUSH);

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    btb_assoc_entry #(.ADDR_W(ADDR_W)) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        ((state_r == BTB_FLUSH) && (idx_r == IDX_W'(gi))),
      .alloc      (alloc_go_s && (rr_ptr_r == IDX_W'(gi))),
      .upd_en     (upd_go_s && upd_match_s[gi]),
      .upd_taken  (upd_taken),
      .lkp_pc     (lkp_pc),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .lkp_match  (lkp_match_s[gi]),
      .upd_match  (upd_match_s[gi]),
      .pred_taken (pred_taken_s[gi]),
      .target     (target_s[gi])
    );
  end

  // Next-state logic for the flush sweep.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BTB_IDLE: begin
        if (flush) state_nxt_s = BTB_FLUSH;
        else       state_nxt_s = BTB_IDLE;
      end
      BTB_FLUSH: begin
        if (sweep_last_s) state_nxt_s = BTB_IDLE;
        else              state_nxt_s = BTB_FLUSH;
      end
      default: state_nxt_s = BTB_IDLE;
    endcase
  end

  // State, sweep index and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BTB_IDLE;
      idx_r    <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == BTB_FLUSH) begin
        idx_r <= idx_r + IDX_W'(1'b1);
      end else if (flush) begin
        idx_r <= {IDX_W{1'b0}};
      end
      if ((state_r == BTB_FLUSH) && sweep_last_s) begin
        rr_ptr_r <= {IDX_W{1'b0}};
      end else if (alloc_go_s) begin
        rr_ptr_r <= rr_ptr_r + IDX_W'(1'b1);
      end
    end
  end

  // Priority mux: walk downward so the lowest matching index wins.
  always_comb begin
    lkp_hit    = 1'b0;
    lkp_target = {ADDR_W{1'b0}};
    lkp_taken  = 1'b0;
    if (state_r == BTB_IDLE) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (lkp_match_s[i]) begin
          lkp_hit    = 1'b1;
          lkp_target = target_s[i];
          lkp_taken  = pred_taken_s[i];
        end else begin
          lkp_hit    = lkp_hit;
        end
      end
    end else begin
      lkp_hit    = 1'b0;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: slot-array model plus directed literal checks.
// Build with BTB_BIMODAL_EN defined to exercise the direction counters.
module tb_btb_assoc;

  localparam int ENTRIES = 8;
  localparam int ADDR_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] lkp_pc = 16'h0000;
  logic              lkp_hit;
  logic [ADDR_W-1:0] lkp_target;
  logic              lkp_taken;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_pc = 16'h0000;
  logic [ADDR_W-1:0] upd_target = 16'h0000;
  logic              upd_taken = 1'b0;
  logic              flush = 1'b0;
  logic              busy;

  btb_assoc #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .lkp_pc(lkp_pc), .lkp_hit(lkp_hit),
    .lkp_target(lkp_target), .lkp_taken(lkp_taken), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: plain slot arrays, a round-robin slot number and a flush countdown.
  bit          m_valid [ENTRIES];
  logic [15:0] m_tag   [ENTRIES];
  logic [15:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_rr = 0;
  int          m_flush_left = 0;

  function automatic int m_find(input logic [15:0] pc);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_rr = 0;
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 16'h0; m_tgt[i] = 16'h0; m_ctr[i] = 2;
    end
    forever begin
      int k;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear();
        m_flush_left = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (flush) begin
        m_clear();
        m_flush_left = ENTRIES;
      end else if (upd_valid) begin
        k = m_find(upd_pc);
        if (k >= 0) begin
          if (upd_taken) m_tgt[k] = upd_target;
          if (upd_taken) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
          else           m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
        end else if (upd_taken) begin
          m_valid[m_rr] = 1'b1; m_tag[m_rr] = upd_pc;
          m_tgt[m_rr] = upd_target; m_ctr[m_rr] = 2;
          m_rr = (m_rr + 1) % ENTRIES;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      int k;
      logic eh, ek;
      logic [15:0] et;
      @(negedge clk);
      eh = 1'b0; et = 16'h0; ek = 1'b0;
      k = (m_flush_left == 0) ? m_find(lkp_pc) : -1;
      if (k >= 0) begin
        eh = 1'b1;
        et = m_tgt[k];
`ifdef BTB_BIMODAL_EN
        ek = (m_ctr[k] >= 2);
`else
        ek = 1'b1;
`endif
      end
      chk("model_hit", {31'd0, lkp_hit}, {31'd0, eh});
      chk("model_target", {16'd0, lkp_target}, {16'd0, et});
      chk("model_taken", {31'd0, lkp_taken}, {31'd0, ek});
      chk("model_busy", {31'd0, busy}, {31'd0, (m_flush_left > 0)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic probe(input string name, input logic [15:0] pc,
                       input logic eh, input logic [15:0] et, input logic ek);
    lkp_pc = pc;
    @(negedge clk);
    chk({name, "_hit"}, {31'd0, lkp_hit}, {31'd0, eh});
    chk({name, "_target"}, {16'd0, lkp_target}, {16'd0, et});
    chk({name, "_taken"}, {31'd0, lkp_taken}, {31'd0, ek});
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int busy_cnt;
    // Reset state.
    do_reset();
    probe("reset", 16'h1000, 1'b0, 16'h0000, 1'b0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // Same-cycle lookup sees pre-update contents; next cycle hits.
    lkp_pc = 16'h1000;
    upd_valid = 1'b1; upd_pc = 16'h1000; upd_target = 16'h2000; upd_taken = 1'b1;
    @(negedge clk);
    chk("same_cycle_hit", {31'd0, lkp_hit}, 32'd0);
    tick();
    upd_valid = 1'b0;
    probe("first", 16'h1000, 1'b1, 16'h2000, 1'b1);

    // ENTRIES+1 allocations wrap the round-robin pointer onto entry 0.
    do_reset();
    for (int i = 0; i <= ENTRIES; i++)
      upd(16'h0100 + 16'(2 * i), 16'h3000 + 16'(i), 1'b1);
    probe("wrap_first", 16'h0100, 1'b0, 16'h0000, 1'b0);
    probe("wrap_last", 16'h0110, 1'b1, 16'h3008, 1'b1);
    upd(16'h0104, 16'h4444, 1'b1);
    probe("rewrite", 16'h0104, 1'b1, 16'h4444, 1'b1);
    probe("rr_next", 16'h0102, 1'b1, 16'h3001, 1'b1);

    // Direction counters (entry 1 replaced by 0200).
    upd(16'h0200, 16'h5000, 1'b1);
    upd(16'h0200, 16'h5555, 1'b0);
    upd(16'h0200, 16'h5555, 1'b0);
`ifdef BTB_BIMODAL_EN
    probe("ctr_low", 16'h0200, 1'b1, 16'h5000, 1'b0);
`else
    probe("nt_nochange", 16'h0200, 1'b1, 16'h5000, 1'b1);
`endif
    upd(16'h0200, 16'h5000, 1'b1);
    upd(16'h0200, 16'h5000, 1'b1);
    probe("ctr_back", 16'h0200, 1'b1, 16'h5000, 1'b1);

    // Flush with a coincident update; second pulse mid-sweep is ignored.
    lkp_pc = 16'h0110;
    flush = 1'b1;
    upd_valid = 1'b1; upd_pc = 16'h0700; upd_target = 16'h7000; upd_taken = 1'b1;
    tick();
    flush = 1'b0; upd_valid = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        chk("sweep_miss", {31'd0, lkp_hit}, 32'd0);
      end
      tick();
      flush = (c == 2);
    end
    flush = 1'b0;
    chk("busy_cycles", busy_cnt, ENTRIES);
    probe("dropped_upd", 16'h0700, 1'b0, 16'h0000, 1'b0);
    probe("flushed", 16'h0110, 1'b0, 16'h0000, 1'b0);

    // Reset mid-sweep, then round-robin restarts at entry 0.
    upd(16'h0800, 16'h8000, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    lkp_pc = 16'h0800;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hit", {31'd0, lkp_hit}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < ENTRIES; i++)
      upd(16'h0900 + 16'(2 * i), 16'h9000 + 16'(i), 1'b1);
    probe("post_rst_hit", 16'h0900, 1'b1, 16'h9000, 1'b1);
    upd(16'h0A00, 16'hA000, 1'b1);
    probe("post_rst_evict0", 16'h0900, 1'b0, 16'h0000, 1'b0);
    probe("post_rst_keep1", 16'h0902, 1'b1, 16'h9001, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
